// File: rtl/goertzel_sample_buffer.sv
// goertzel_sample_buffer
// Ping-pong sample store between the ADC capture front end and the Goertzel
// inner loop. The producer fills the write bank while the reader walks the
// read bank by sample_address. Banks swap only when the reader presents the
// last address of a frame and the write bank is full, so every Goertzel frame
// sees 2^ADDR_W contiguous samples.
//
// Optional feature: define GOERTZEL_SBUF_DROP_STATS_EN to build the saturating
// dropped-sample counter on drop_count. When it is undefined, drop_count is
// tied to zero and the overrun flag behaves the same.
module goertzel_sample_buffer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              dsp_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_in_valid,
  input  logic [ADDR_W-1:0] sample_address,
  output logic [DATA_W-1:0] data,
  output logic              frame_ready,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [ADDR_W:0]   fill_level,
  output logic [15:0]       drop_count
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // Two single-write / single-read banks, kept as separate arrays so each maps
  // onto its own block RAM.
  logic signed [DATA_W-1:0] bank0 [DEPTH];
  logic signed [DATA_W-1:0] bank1 [DEPTH];

  // Bank control state
  logic              rd_bank;
  logic              full;
  logic              primed;
  logic [ADDR_W-1:0] wr_ptr;

  logic              rd_bank_nxt;
  logic              full_nxt;
  logic              primed_nxt;
  logic [ADDR_W-1:0] wr_ptr_nxt;
  logic              frame_ready_nxt;
  logic              overrun_nxt;

  // Write-port decode
  logic              swap;
  logic              drop;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic signed [DATA_W-1:0] wr_data_p0;

  // Read pipeline: address in stage p0, RAM word and its qualifiers in p1
  logic signed [DATA_W-1:0] rd_q0_p1;
  logic signed [DATA_W-1:0] rd_q1_p1;
  logic                     rd_sel_p1;
  logic                     vld_p1;

  assign wr_data_p0 = $signed(sample_in);

  // Swap, write and drop decode plus next-state for the bank control registers
  always_comb begin
    swap            = full && (sample_address == LAST_ADDR);
    drop            = sample_in_valid && full && !swap;
    // On the swap edge the old read bank becomes the write bank and takes the
    // incoming sample at address 0; otherwise the write bank is !rd_bank.
    wr_en           = sample_in_valid && (!full || swap);
    wr_sel          = swap ? rd_bank : ~rd_bank;
    wr_addr         = swap ? '0 : wr_ptr;

    rd_bank_nxt     = rd_bank;
    full_nxt        = full;
    primed_nxt      = primed;
    wr_ptr_nxt      = wr_ptr;
    frame_ready_nxt = swap;
    overrun_nxt     = overrun;

    if (swap) begin
      rd_bank_nxt = ~rd_bank;
      full_nxt    = 1'b0;
      primed_nxt  = 1'b1;
      wr_ptr_nxt  = sample_in_valid ? ADDR_W'(1) : '0;
    end else if (wr_en) begin
      wr_ptr_nxt = wr_ptr + 1'b1;
      if (wr_ptr == LAST_ADDR) begin
        full_nxt = 1'b1;
      end
    end

    // A drop in the same cycle as a clear keeps the flag set
    if (drop) begin
      overrun_nxt = 1'b1;
    end else if (overrun_clr) begin
      overrun_nxt = 1'b0;
    end
  end

  // Bank control registers
  always_ff @(posedge dsp_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank     <= 1'b0;
      full        <= 1'b0;
      primed      <= 1'b0;
      wr_ptr      <= '0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rd_bank     <= rd_bank_nxt;
      full        <= full_nxt;
      primed      <= primed_nxt;
      wr_ptr      <= wr_ptr_nxt;
      frame_ready <= frame_ready_nxt;
      overrun     <= overrun_nxt;
    end
  end

  // wr_ptr sits at 0 whenever full is set, so the concatenation spans 0..DEPTH
  assign fill_level = {full, wr_ptr};

  // ---- stage p0 -> p1: bank 0 write port and synchronous read ----
  // Bank 0 storage; contents are not reset, primed hides them until a swap
  always_ff @(posedge dsp_clk) begin
    if (wr_en && !wr_sel) begin
      bank0[wr_addr] <= wr_data_p0;
    end
    rd_q0_p1 <= bank0[sample_address];
  end

  // Bank 1 storage; same structure as bank 0
  always_ff @(posedge dsp_clk) begin
    if (wr_en && wr_sel) begin
      bank1[wr_addr] <= wr_data_p0;
    end
    rd_q1_p1 <= bank1[sample_address];
  end

  // Bank select and primed qualifier travel with the RAM word into p1
  always_ff @(posedge dsp_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_p1 <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      rd_sel_p1 <= rd_bank;
      vld_p1    <= primed;
    end
  end

  // ---- stage p1 output: unprimed or freshly reset reads return zero ----
  assign data = vld_p1 ? (rd_sel_p1 ? rd_q1_p1 : rd_q0_p1) : '0;

`ifdef GOERTZEL_SBUF_DROP_STATS_EN
  logic [15:0] drop_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Dropped-sample counter: saturates, cleared with overrun; a drop during a
  // clear restarts the count at 1
  always_ff @(posedge dsp_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= overrun_clr ? 16'd1 : sat_inc16(drop_cnt);
    end else if (overrun_clr) begin
      drop_cnt <= '0;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_goertzel_sample_buffer.sv
// Bench for goertzel_sample_buffer: directed scenarios, a vector table for the
// overrun/clear interplay and a randomized run, all against a frame-level
// model that keeps the write bank as a queue of accepted samples.
module tb_goertzel_sample_buffer;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;
`ifdef GOERTZEL_SBUF_DROP_STATS_EN
  localparam int DC_ON = 1;
`else
  localparam int DC_ON = 0;
`endif

  logic              dsp_clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] sample_in;
  logic              sample_in_valid;
  logic [ADDR_W-1:0] sample_address;
  logic [DATA_W-1:0] data;
  logic              frame_ready;
  logic              overrun;
  logic              overrun_clr;
  logic [ADDR_W:0]   fill_level;
  logic [15:0]       drop_count;

  always #5 dsp_clk = ~dsp_clk;

  goertzel_sample_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .dsp_clk        (dsp_clk),
    .rst_n          (rst_n),
    .sample_in      (sample_in),
    .sample_in_valid(sample_in_valid),
    .sample_address (sample_address),
    .data           (data),
    .frame_ready    (frame_ready),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr),
    .fill_level     (fill_level),
    .drop_count     (drop_count)
  );

  int checks = 0;
  int passes = 0;

  // Model state: accepted samples of the current write bank, the frame the
  // reader sees, and the sticky/pulse outputs
  logic [15:0]       wq[$];
  logic [15:0]       rf [DEPTH];
  bit                m_primed;
  bit                m_fr;
  bit                m_ovr;
  int                m_dc;
  logic [15:0]       m_data;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] fr_at;
  int                frames;

  typedef struct {
    bit          v;
    logic [15:0] s;
    bit          clr;
    int          exp_fill;
    bit          exp_ovr;
    int          exp_drops;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (addr %0d)", name, act, exp, addr);
  endtask

  task automatic m_reset();
    wq.delete();
    m_primed = 1'b0;
    m_fr     = 1'b0;
    m_ovr    = 1'b0;
    m_dc     = 0;
    m_data   = '0;
  endtask

  // One reader cycle at address addr; the model advances on the same edge
  task automatic step(input bit v, input logic [15:0] s, input bit clr);
    bit sw, dr;
    sample_in_valid = v;
    sample_in       = s;
    overrun_clr     = clr;
    sample_address  = addr;
    sw = (addr == ADDR_W'(DEPTH - 1)) && (wq.size() == DEPTH);
    dr = v && (wq.size() == DEPTH) && !sw;
    m_data = m_primed ? rf[addr] : 16'h0000;
    if (sw) begin
      for (int i = 0; i < DEPTH; i++) rf[i] = wq[i];
      wq.delete();
      m_primed = 1'b1;
      if (v) wq.push_back(s);
    end else if (v && !dr) begin
      wq.push_back(s);
    end
    m_fr = sw;
    if (dr) begin
      m_ovr = 1'b1;
      m_dc  = clr ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
    end else if (clr) begin
      m_ovr = 1'b0;
      m_dc  = 0;
    end
    @(posedge dsp_clk);
    @(negedge dsp_clk);
    check("data", data, m_data);
    check("frame_ready", frame_ready, m_fr);
    check("fill_level", fill_level, wq.size());
    check("overrun", overrun, m_ovr);
    check("drop_count", drop_count, m_dc * DC_ON);
    if (frame_ready) begin
      frames++;
      fr_at = addr + 1'b1;
    end
    addr = addr + 1'b1;
  endtask

  task automatic idle_to(input int target);
    for (int i = 0; i < DEPTH && int'(addr) != target; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic writes(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) step(1'b1, base + 16'(k), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    tbl[0] = '{1'b0, 16'h0000, 1'b1, 512, 1'b0, 0};
    tbl[1] = '{1'b1, 16'hE001, 1'b0, 512, 1'b1, 1};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 512, 1'b0, 0};
    tbl[3] = '{1'b1, 16'hE003, 1'b1, 512, 1'b1, 1};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 512, 1'b1, 1};

    rst_n = 1'b0; sample_in = '0; sample_in_valid = 1'b0;
    overrun_clr = 1'b0; sample_address = '0; addr = '0; fr_at = '0; frames = 0;
    m_reset();
    #12;
    check("rst_data", data, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fill", fill_level, 0);
    check("rst_drop_count", drop_count, 0);
    @(negedge dsp_clk);
    rst_n = 1'b1;

    // Idle reader, no writes
    frames = 0;
    repeat (1024) step(1'b0, 16'h0, 1'b0);
    check("idle_frames", frames, 0);

    // Fill with value = index, swap at the next address 511, read back
    writes(DEPTH, 16'h0000);
    check("fill_full", fill_level, 512);
    repeat (DEPTH) step(1'b0, 16'h0, 1'b0);
    check("swap_frames", frames, 1);
    check("swap_fr_addr", fr_at, 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 16'h0, 1'b0);
      if (data != 16'(i)) bad++;
    end
    check("frame_seq_bad", bad, 0);
    check("frames_after_read", frames, 1);

    // Overrun: bank fills with reader at 100, three further samples dropped
    idle_to(101);
    writes(DEPTH, 16'h1000);
    check("ovr_fill", fill_level, 512);
    for (int j = 0; j < 3; j++) step(1'b1, 16'hD000 + 16'(j), 1'b0);
    check("ovr_flag", overrun, 1);
    check("ovr_drops", drop_count, 3 * DC_ON);
    idle_to(0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 16'h0, 1'b0);
      if (data == 16'hD000 || data == 16'hD001 || data == 16'hD002) bad++;
    end
    check("dropped_absent", bad, 0);

    // Clear/drop interplay on a full bank, from the vector table
    writes(DEPTH, 16'h2000);
    for (int t = 0; t < 5; t++) begin
      step(tbl[t].v, tbl[t].s, tbl[t].clr);
      check($sformatf("tbl%0d_overrun", t), overrun, tbl[t].exp_ovr);
      check($sformatf("tbl%0d_fill", t), fill_level, tbl[t].exp_fill);
      check($sformatf("tbl%0d_drops", t), drop_count, tbl[t].exp_drops * DC_ON);
    end

    // Sample arriving on the swap edge lands at address 0 of the new write bank
    idle_to(511);
    step(1'b1, 16'h7FFF, 1'b0);
    check("sim_frame_ready", frame_ready, 1);
    check("sim_fill", fill_level, 1);
    check("sim_overrun", overrun, 1);
    check("sim_drops", drop_count, DC_ON);
    writes(DEPTH - 1, 16'h3000);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("sim_data_addr0", data, 16'h7FFF);

    // Asynchronous reset mid-frame
    idle_to(100);
    writes(200, 16'h4000);
    check("pre_rst_fill", fill_level, 200);
    sample_address = addr;
    sample_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", data, 0);
    check("arst_frame_ready", frame_ready, 0);
    check("arst_overrun", overrun, 0);
    check("arst_fill", fill_level, 0);
    check("arst_drop_count", drop_count, 0);
    m_reset();
    @(negedge dsp_clk);
    rst_n = 1'b1;
    addr = addr + 1'b1;
    frames = 0;
    writes(DEPTH - 1, 16'h5000);
    repeat (600) step(1'b0, 16'h0, 1'b0);
    check("partial_no_frame", frames, 0);
    check("partial_fill", fill_level, 511);
    step(1'b1, 16'h51FF, 1'b0);
    for (int i = 0; i < 1100 && frames == 0; i++) step(1'b0, 16'h0, 1'b0);
    check("refill_frame", frames, 1);

    // Randomized producer and clear traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 85, 16'($urandom), $urandom_range(0, 99) < 3);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
